// File: rtl/cover_eval_sched.sv
// Shared point buffer and radius-coverage evaluator for two scan requesters.
// Define SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins every tie).
module cover_eval_sched #(
    parameter int NPTS = 40,
    parameter int R2   = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LD_VALID,
    input  logic [3:0] LD_X,
    input  logic [3:0] LD_Y,
    input  logic       LD_CLR,
    output logic       PTS_FULL,
    input  logic [1:0] REQ_VALID,
    output logic [1:0] REQ_READY,
    input  logic [7:0] REQ_CX,
    input  logic [7:0] REQ_CY,
    input  logic [7:0] REQ_OX,
    input  logic [7:0] REQ_OY,
    input  logic [1:0] REQ_UNION,
    output logic       RSP_VALID,
    output logic       RSP_ID,
    output logic [5:0] RSP_CNT,
    output logic [5:0] RSP_INTER,
    output logic       BUSY
);
    localparam int IW = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam logic [5:0] LAST = 6'(NPTS - 1);
    localparam logic [5:0] FULL = 6'(NPTS);
    localparam logic [8:0] R2V = 9'(R2);

    typedef enum logic [1:0] {IDLE, WALK, DRAIN, RESP} state_e;

    function automatic logic [3:0] absd(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [8:0] sq(input logic [3:0] d);
        logic [7:0] p;
        p = {4'd0, d} * {4'd0, d};
        return {1'b0, p};
    endfunction

    state_e     state_q, state_d;
    logic [5:0] ld_cnt_q, ld_cnt_d;
    logic [5:0] idx_q, idx_d;
    logic [5:0] acc_q, acc_d;
    logic [5:0] inter_q, inter_d;
    logic [3:0] cx_q, cx_d, cy_q, cy_d;
    logic [3:0] ox_q, ox_d, oy_q, oy_d;
    logic       union_q, union_d;
    logic       id_q, id_d;
    logic       s1_v_q;
    logic [3:0] dcx_q, dcy_q, dox_q, doy_q;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q, rsp_id_d;
    logic [5:0] rsp_cnt_q, rsp_cnt_d;
    logic [5:0] rsp_inter_q, rsp_inter_d;
    logic [7:0] pts_q [NPTS];
    logic [7:0] pt;
    logic       ld_we;
    logic [1:0] gnt;
    logic       gid;
    logic       tie_win;
    logic [8:0] sum_c, sum_o;
    logic       in_c, in_o, hit;

`ifdef SCHED_FIXED_PRIO_EN
    assign tie_win = 1'b0;
`else
    logic rr_last_q, rr_last_d;

    always_comb rr_last_d = (|gnt) ? gid : rr_last_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) rr_last_q <= 1'b1;
        else     rr_last_q <= rr_last_d;
    end

    assign tie_win = ~rr_last_q;
`endif

    assign PTS_FULL  = (ld_cnt_q == FULL);
    assign BUSY      = (state_q != IDLE);
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ID    = rsp_id_q;
    assign RSP_CNT   = rsp_cnt_q;
    assign RSP_INTER = rsp_inter_q;
    assign REQ_READY = gnt;
    assign gid       = gnt[1];
    assign pt        = pts_q[idx_q[IW-1:0]];

    always_comb begin
        gnt = 2'b00;
        if (state_q == IDLE && PTS_FULL) begin
            unique case (REQ_VALID)
                2'b01, 2'b10: gnt = REQ_VALID;
                2'b11:        gnt = tie_win ? 2'b10 : 2'b01;
                default:      gnt = 2'b00;
            endcase
        end
    end

    // Second pipeline stage: squared distances of the point registered last cycle
    assign sum_c = sq(dcx_q) + sq(dcy_q);
    assign sum_o = sq(dox_q) + sq(doy_q);
    assign in_c  = (sum_c <= R2V);
    assign in_o  = (sum_o <= R2V);
    assign hit   = union_q ? (in_c | in_o) : in_c;

    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        inter_d     = inter_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        union_d     = union_q;
        id_d        = id_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_cnt_d   = rsp_cnt_q;
        rsp_inter_d = rsp_inter_q;
        ld_we       = 1'b0;
        if (s1_v_q) begin
            acc_d   = acc_q + {5'd0, hit};
            inter_d = inter_q + {5'd0, union_q & in_c & in_o};
        end
        unique case (state_q)
            IDLE: begin
                if (LD_CLR) begin
                    ld_cnt_d = '0;
                end else if (LD_VALID && !PTS_FULL) begin
                    ld_we    = 1'b1;
                    ld_cnt_d = ld_cnt_q + 6'd1;
                end
                if (|gnt) begin
                    state_d = WALK;
                    idx_d   = '0;
                    acc_d   = '0;
                    inter_d = '0;
                    cx_d    = gid ? REQ_CX[7:4] : REQ_CX[3:0];
                    cy_d    = gid ? REQ_CY[7:4] : REQ_CY[3:0];
                    ox_d    = gid ? REQ_OX[7:4] : REQ_OX[3:0];
                    oy_d    = gid ? REQ_OY[7:4] : REQ_OY[3:0];
                    union_d = REQ_UNION[gid];
                    id_d    = gid;
                end
            end
            WALK: begin
                idx_d = idx_q + 6'd1;
                if (idx_q == LAST) state_d = DRAIN;
            end
            DRAIN: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_cnt_d   = acc_d;
                rsp_inter_d = inter_d;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (ld_we) pts_q[ld_cnt_q[IW-1:0]] <= {LD_X, LD_Y};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            ld_cnt_q    <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            inter_q     <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            union_q     <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_cnt_q   <= '0;
            rsp_inter_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            inter_q     <= inter_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            union_q     <= union_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_cnt_q   <= rsp_cnt_d;
            rsp_inter_q <= rsp_inter_d;
        end
    end

    // First pipeline stage: per-axis distance of the current point to both centres
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_v_q <= 1'b0;
            dcx_q  <= '0;
            dcy_q  <= '0;
            dox_q  <= '0;
            doy_q  <= '0;
        end else begin
            s1_v_q <= (state_q == WALK);
            dcx_q  <= absd(pt[7:4], cx_q);
            dcy_q  <= absd(pt[3:0], cy_q);
            dox_q  <= absd(pt[7:4], ox_q);
            doy_q  <= absd(pt[3:0], oy_q);
        end
    end

endmodule
